// File: rtl/serial_sub.sv
// -----------------------------------------------------------------------------
// serial_sub
//   Bit-serial subtractor computing diff = a - b (modulo 2^WIDTH), one bit per
//   clock, LSB first. A single borrow flop plus shift registers replace a
//   WIDTH-bit ripple-borrow chain.
//
//   Operation timeline (E0 = accept edge):
//     E0            : IDLE & start -> operands latched, enter SHIFT, busy=1
//     E1 .. EWIDTH  : one difference bit per edge; the last one enters DONE
//     EWIDTH+1      : DONE -> IDLE, diff/borrow(/ovf) loaded, done pulses
//   start is only looked at in IDLE, so requests during SHIFT/DONE are dropped.
//   With start held high the next accept is EWIDTH+2.
//
// Parameters
//   WIDTH   operand/result width in bits (>= 2)
//
// Ports
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset
//   start   operation request, sampled only in IDLE
//   a, b    minuend / subtrahend, captured on the accept edge
//   busy    high while shifting
//   done    one-cycle pulse; diff/borrow valid from this cycle on
//   diff    a - b modulo 2^WIDTH, held until the next result
//   borrow  final borrow-out, 1 iff a < b (unsigned)
//   ovf     two's-complement overflow of the subtraction
//
// Configuration
//   SERIAL_SUB_OVF_EN  when defined, adds the ovf port and the operand-MSB
//                      capture that feeds it.
// -----------------------------------------------------------------------------
module serial_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Full-subtractor cell: difference bit
  function automatic logic sub_diff_bit(input logic a0, input logic b0, input logic bin);
    sub_diff_bit = a0 ^ b0 ^ bin;
  endfunction

  // Full-subtractor cell: borrow-out
  function automatic logic sub_borrow_bit(input logic a0, input logic b0, input logic bin);
    sub_borrow_bit = (~a0 & b0) | (~(a0 ^ b0) & bin);
  endfunction

  state_t             state_r;
  logic [WIDTH-1:0]   a_sh_r;
  logic [WIDTH-1:0]   b_sh_r;
  // Result is assembled here so diff never shows partial values.
  logic [WIDTH-1:0]   res_sh_r;
  logic               bin_r;
  logic [CNT_W-1:0]   cnt_r;

`ifdef SERIAL_SUB_OVF_EN
  // Operand sign bits are lost to the right shift, so keep copies.
  logic               a_msb_r;
  logic               b_msb_r;
`endif

  logic               d_s;
  logic               bout_s;

  // Current bit of the serial subtraction
  always_comb begin
    d_s    = 1'b0;
    bout_s = 1'b0;
    d_s    = sub_diff_bit(a_sh_r[0], b_sh_r[0], bin_r);
    bout_s = sub_borrow_bit(a_sh_r[0], b_sh_r[0], bin_r);
  end

  // Control FSM, datapath shift registers and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      a_sh_r   <= {WIDTH{1'b0}};
      b_sh_r   <= {WIDTH{1'b0}};
      res_sh_r <= {WIDTH{1'b0}};
      bin_r    <= 1'b0;
      cnt_r    <= {CNT_W{1'b0}};
      busy     <= 1'b0;
      done     <= 1'b0;
      diff     <= {WIDTH{1'b0}};
      borrow   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      a_msb_r  <= 1'b0;
      b_msb_r  <= 1'b0;
      ovf      <= 1'b0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sh_r   <= a;
            b_sh_r   <= b;
            res_sh_r <= {WIDTH{1'b0}};
            bin_r    <= 1'b0;
            cnt_r    <= {CNT_W{1'b0}};
            busy     <= 1'b1;
            state_r  <= ST_SHIFT;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_r  <= a[WIDTH-1];
            b_msb_r  <= b[WIDTH-1];
`endif
          end else begin
            busy    <= 1'b0;
            state_r <= ST_IDLE;
          end
        end

        ST_SHIFT: begin
          done     <= 1'b0;
          // Difference bits enter from the MSB side; after WIDTH shifts
          // the first (LSB) bit has reached position 0.
          res_sh_r <= {d_s, res_sh_r[WIDTH-1:1]};
          a_sh_r   <= {1'b0, a_sh_r[WIDTH-1:1]};
          b_sh_r   <= {1'b0, b_sh_r[WIDTH-1:1]};
          bin_r    <= bout_s;
          cnt_r    <= cnt_r + CNT_W'(1);
          if (cnt_r == LAST_CNT) begin
            busy    <= 1'b0;
            state_r <= ST_DONE;
          end else begin
            busy    <= 1'b1;
            state_r <= ST_SHIFT;
          end
        end

        ST_DONE: begin
          // bin_r now holds the borrow-out of the MSB cell.
          diff    <= res_sh_r;
          borrow  <= bin_r;
`ifdef SERIAL_SUB_OVF_EN
          ovf     <= (a_msb_r != b_msb_r) & (res_sh_r[WIDTH-1] != a_msb_r);
`endif
          done    <= 1'b1;
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end

        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
